// File: rtl/msg_pkg.sv
// ============================================================================
// msg_pkg
// Shared constants for the status-text buffer: message IDs, the fill
// character and the encoding of the fill/load state machine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package msg_pkg;

  // Message identifiers carried on msg_sel
  localparam logic [2:0] MSG_START  = 3'd0;
  localparam logic [2:0] MSG_TURN_X = 3'd1;
  localparam logic [2:0] MSG_TURN_O = 3'd2;
  localparam logic [2:0] MSG_WIN_X  = 3'd3;
  localparam logic [2:0] MSG_WIN_O  = 3'd4;
  localparam logic [2:0] MSG_DRAW   = 3'd5;

  // Fill and pad character (ASCII space)
  localparam logic [7:0] SPACE_CODE = 8'h20;

  // CLEAR sweeps the whole RAM, IDLE waits, LOAD writes one row-0 message
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/msg_rom.sv
// ============================================================================
// msg_rom
// Combinational lookup of the fixed status messages. Returns the ASCII
// code for column col_i of message sel_i; columns past the end of the
// message, and unknown message IDs, return the pad character.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module msg_rom
  import msg_pkg::*;
#(
  parameter logic [7:0] PAD_CODE = 8'h20
) (
  input  logic [2:0] sel_i,
  input  logic [3:0] col_i,
  output logic [7:0] code_o
);

  // Text is stored left-justified: column 0 is the most significant byte
  logic [127:0] w_text;
  logic [4:0]   w_len;

  // Select message text and its printable length
  always_comb begin
    w_text = {16{PAD_CODE}};
    w_len  = 5'd0;
    case (sel_i)
      MSG_START:  begin w_text = "PRESS START     "; w_len = 5'd11; end
      MSG_TURN_X: begin w_text = "PLAYER X TURN   "; w_len = 5'd13; end
      MSG_TURN_O: begin w_text = "PLAYER O TURN   "; w_len = 5'd13; end
      MSG_WIN_X:  begin w_text = "X WINS          "; w_len = 5'd6;  end
      MSG_WIN_O:  begin w_text = "O WINS          "; w_len = 5'd6;  end
      MSG_DRAW:   begin w_text = "DRAW            "; w_len = 5'd4;  end
      default:    begin w_text = {16{PAD_CODE}};     w_len = 5'd0;  end
    endcase
  end

  // Byte for column c sits at bit offset 8*(15-c); 15-c is ~c in 4 bits
  always_comb begin
    code_o = PAD_CODE;
    if ({1'b0, col_i} < w_len) begin
      code_o = w_text[{~col_i, 3'b000} +: 8];
    end
  end

endmodule

`default_nettype wire

// File: rtl/msg_text_buffer.sv
// ============================================================================
// msg_text_buffer
// 16x16 character-code buffer for on-screen status text. After reset the
// whole grid is filled with spaces; on request one of six fixed messages
// is written into row 0, one character per cycle. A single pending slot
// (last request wins) queues a request that arrives while busy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module msg_text_buffer #(
  parameter int         MSG_COLS   = 16,
  parameter logic [7:0] SPACE_CODE = msg_pkg::SPACE_CODE
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] char_xy,
  output logic [7:0] char_code,
  input  logic [2:0] msg_sel,
  input  logic       msg_load,
  output logic       busy,
  output logic       done
);

  import msg_pkg::*;

  localparam logic [3:0] LAST_COL  = 4'(MSG_COLS - 1);
  localparam logic [7:0] LAST_ADDR = 8'hFF;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic        pend_q, pend_d;
  logic [2:0]  psel_q, psel_d;
  logic        done_q, done_d;
  logic [7:0]  char_code_q;

  logic        w_we;
  logic [7:0]  w_waddr;
  logic [7:0]  w_wdata;
  logic [7:0]  w_rom_code;
  logic        w_req_any;
  logic [2:0]  w_req_sel;

  logic [7:0]  mem_q [256];

  msg_rom #(
    .PAD_CODE (SPACE_CODE)
  ) u_rom (
    .sel_i  (sel_q),
    .col_i  (cnt_q[3:0]),
    .code_o (w_rom_code)
  );

  // A request in the final write cycle counts as pending and overrides an older one
  assign w_req_any = pend_q | msg_load;
  assign w_req_sel = msg_load ? msg_sel : psel_q;

  // Next-state, counters, pending slot and RAM write port
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    psel_d  = psel_q;
    done_d  = 1'b0;
    w_we    = 1'b0;
    w_waddr = cnt_q;
    w_wdata = SPACE_CODE;

    case (state_q)
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = cnt_q;
        w_wdata = SPACE_CODE;
        cnt_d   = cnt_q + 8'd1;
        if (msg_load) begin
          pend_d = 1'b1;
          psel_d = msg_sel;
        end
        if (cnt_q == LAST_ADDR) begin
          cnt_d = 8'd0;
          if (w_req_any) begin
            state_d = ST_LOAD;
            sel_d   = w_req_sel;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_IDLE: begin
        if (msg_load) begin
          sel_d   = msg_sel;
          cnt_d   = 8'd0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        w_we    = 1'b1;
        w_waddr = {4'h0, cnt_q[3:0]};
        w_wdata = w_rom_code;
        cnt_d   = cnt_q + 8'd1;
        if (msg_load) begin
          pend_d = 1'b1;
          psel_d = msg_sel;
        end
        if (cnt_q[3:0] == LAST_COL) begin
          done_d = 1'b1;
          cnt_d  = 8'd0;
          if (w_req_any) begin
            state_d = ST_LOAD;
            sel_d   = w_req_sel;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Control registers; reset aborts any operation and restarts the clear sweep
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= 8'd0;
      sel_q   <= 3'd0;
      pend_q  <= 1'b0;
      psel_q  <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      psel_q  <= psel_d;
      done_q  <= done_d;
    end
  end

  // Character RAM write port; contents survive reset and are swept by CLEAR
  always_ff @(posedge pclk) begin
    if (w_we) begin
      mem_q[w_waddr] <= w_wdata;
    end
  end

  // Registered read port; a same-address write in this cycle is not seen (read-first)
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      char_code_q <= SPACE_CODE;
    end else begin
      char_code_q <= mem_q[char_xy];
    end
  end

  assign char_code = char_code_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_msg_text_buffer.sv
// ============================================================================
// tb_msg_text_buffer
// Directed bench for msg_text_buffer with a behavioural reference model
// and per-cycle output comparison.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msg_text_buffer;

  logic       pclk     = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] char_xy  = 8'h00;
  logic [2:0] msg_sel  = 3'd0;
  logic       msg_load = 1'b0;
  logic [7:0] char_code;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  msg_text_buffer #(
    .MSG_COLS   (16),
    .SPACE_CODE (8'h20)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .char_xy   (char_xy),
    .char_code (char_code),
    .msg_sel   (msg_sel),
    .msg_load  (msg_load),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  string txt [8] = '{"PRESS START", "PLAYER X TURN", "PLAYER O TURN",
                     "X WINS", "O WINS", "DRAW", "", ""};

  function automatic logic [7:0] msg_char(input int sel, input int col);
    string s;
    s = txt[sel];
    if (col < s.len()) return s[col];
    return 8'h20;
  endfunction

  logic [7:0] m_mem   [256];
  bit         m_known [256];
  bit         m_valid    = 0;
  bit         m_clearing = 1;
  bit         m_loading  = 0;
  bit         m_pend     = 0;
  bit         m_done     = 0;
  bit         m_code_ok  = 1;
  int         m_clr      = 0;
  int         m_col      = 0;
  int         m_sel      = 0;
  int         m_psel     = 0;
  logic [7:0] m_code     = 8'h20;
  bit         m_finish;

  always @(posedge pclk or posedge rst) begin
    if (rst) begin
      m_valid    = 1;
      m_clearing = 1;
      m_loading  = 0;
      m_pend     = 0;
      m_done     = 0;
      m_clr      = 0;
      m_code     = 8'h20;
      m_code_ok  = 1;
    end else begin
      m_code    = m_mem[char_xy];
      m_code_ok = m_known[char_xy];
      m_done    = 0;
      m_finish  = 0;
      if (m_clearing || m_loading) begin
        if (msg_load) begin
          m_pend = 1;
          m_psel = msg_sel;
        end
        if (m_clearing) begin
          m_mem[m_clr]   = 8'h20;
          m_known[m_clr] = 1;
          m_clr++;
          if (m_clr == 256) begin
            m_clearing = 0;
            m_finish   = 1;
          end
        end else begin
          m_mem[m_col]   = msg_char(m_sel, m_col);
          m_known[m_col] = 1;
          m_col++;
          if (m_col == 16) begin
            m_loading = 0;
            m_done    = 1;
            m_finish  = 1;
          end
        end
        if (m_finish && m_pend) begin
          m_loading = 1;
          m_col     = 0;
          m_sel     = m_psel;
          m_pend    = 0;
        end
      end else if (msg_load) begin
        m_loading = 1;
        m_col     = 0;
        m_sel     = msg_sel;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge pclk) begin
    if (m_valid && !rst) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_clearing || m_loading)});
      chk("done", {31'd0, done}, {31'd0, m_done});
      if (m_code_ok) chk("char_code", {24'd0, char_code}, {24'd0, m_code});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic pulse_load(input logic [2:0] s);
    msg_sel  = s;
    msg_load = 1'b1;
    tick();
    msg_load = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      tick();
      n++;
      if (done) return;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_addr(input logic [7:0] a, output logic [7:0] d);
    char_xy = a;
    tick();
    d = char_code;
  endtask

  task automatic measure_clear(input string tag);
    int nb;
    int nd;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge pclk);
      if (!busy) break;
      nb++;
      if (done) nd++;
    end
    chk({tag, "_busy_cycles"}, nb, 256);
    chk({tag, "_done_pulses"}, nd, 0);
    tick();
  endtask

  task automatic check_row0(input string tag, input logic [127:0] row);
    logic [7:0] d;
    for (int c = 0; c < 16; c++) begin
      read_addr(8'(c), d);
      chk(tag, {24'd0, d}, {24'd0, row[127 - 8*c -: 8]});
    end
  endtask

  task automatic count_dones(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) nd++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0]   d;
    logic [127:0] row;
    int           n;
    int           nd;

    rst = 1'b1;
    repeat (3) tick();
    chk("reset_busy", {31'd0, busy}, 32'd1);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_code", {24'd0, char_code}, 32'h20);
    rst = 1'b0;

    // Power-up clear
    measure_clear("clear");
    read_addr(8'h00, d); chk("clear_rd_00", {24'd0, d}, 32'h20);
    read_addr(8'h7F, d); chk("clear_rd_7f", {24'd0, d}, 32'h20);
    read_addr(8'hFF, d); chk("clear_rd_ff", {24'd0, d}, 32'h20);

    // Single load "X WINS"
    pulse_load(3'd3);
    wait_done(40, n);
    chk("xwins_latency", n, 16);
    row = 128'h58205749_4E532020_20202020_20202020;
    check_row0("xwins_row", row);

    // Busy-time requests: sel 4 is overwritten by sel 5
    pulse_load(3'd1);
    repeat (3) tick();
    pulse_load(3'd4);
    repeat (2) tick();
    pulse_load(3'd5);
    wait_done(40, n);
    wait_done(40, n);
    chk("b2b_done_spacing", n, 16);
    count_dones(24, nd);
    chk("b2b_extra_done", nd, 0);
    row = 128'h44524157_20202020_20202020_20202020;
    check_row0("draw_row", row);

    // Invalid message ID
    pulse_load(3'd7);
    wait_done(40, n);
    chk("inv_latency", n, 16);
    count_dones(20, nd);
    chk("inv_extra_done", nd, 0);
    row = {16{8'h20}};
    check_row0("inv_row", row);

    // Reset in the middle of a load (column 8 pending)
    pulse_load(3'd2);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    chk("midrst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    measure_clear("midrst");
    for (int a = 0; a < 256; a++) begin
      read_addr(8'(a), d);
      chk("midrst_ram", {24'd0, d}, 32'h20);
    end

    // Read/write collision on address 0x03 during a "PRESS START" load
    char_xy  = 8'h03;
    msg_sel  = 3'd0;
    msg_load = 1'b1;
    tick();
    msg_load = 1'b0;
    repeat (3) tick();
    tick();
    chk("collide_old", {24'd0, char_code}, 32'h20);
    tick();
    chk("collide_new", {24'd0, char_code}, 32'h53);
    wait_done(40, n);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
